sha3_axis_padder: RTL

Upstream stage of the SHA-3 absorb register. Accepts a byte-oriented AXI-Stream message, applies SHA-3 multi-rate padding (domain byte 0x06 … final 0x80) and segments the padded stream into rate-sized blocks. Emits one `DATA_WIDTH` word per beat toward the absorb register:
- `TLAST` marks the last word of each rate block.
- `TID` marks the last word of the final block.
- `TUSER` carries the hash mode.

---
 rtl/sha3_pkg.sv | 38 +++
 rtl/sha3_pad_word.sv | 43 ++++
 rtl/sha3_axis_padder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Purpose : shared types and constants for the SHA-3 input padder.
// Latency : n/a (package only).
// Backpressure: n/a.
// Build option: SHA3_LEGACY_KECCAK_EN selects the original Keccak domain byte (0x01).
// Without it, the FIPS 202 SHA-3 domain byte (0x06) is used.
package sha3_pkg;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_mode_t;

    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_PAD06 = 2'd1,
        ST_PADZ  = 2'd2
    } pad_state_t;

    // Rate in bits, indexed by sha3_mode_t.
    localparam int unsigned RATE_BITS [0:3] = '{1152, 1088, 832, 576};

`ifdef SHA3_LEGACY_KECCAK_EN
    localparam logic [7:0] PAD_DOMAIN = 8'h01;
`else
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
`endif
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    // Words of the given width per rate block. The largest case (1152/8 = 144)
    // still fits in 8 bits.
    function automatic logic [7:0] words_per_block(input sha3_mode_t mode,
                                                   input int unsigned width);
        return 8'(RATE_BITS[mode] / width);
    endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Purpose : builds one padded output word from a data word and its byte enables.
// Latency : combinational.
// Backpressure: none (no handshake).
// Ports: data/keep = input word and byte enables (contiguous from byte 0),
//        pad_first = place the domain byte in the first disabled byte,
//        pad_last  = OR the final pad bit (0x80) into the top byte,
//        word = padded result. Disabled bytes other than the domain byte are 0.
module sha3_pad_word
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] keep,
    input  logic                    pad_first,
    input  logic                    pad_last,
    output logic [DATA_WIDTH-1:0]   word
);

    localparam int NB = DATA_WIDTH / 8;

    logic prev_kept;

    always_comb begin
        word      = '0;
        prev_kept = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (keep[i]) begin
                word[8*i +: 8] = data[8*i +: 8];
            end else if (pad_first && prev_kept) begin
                // First byte past the enabled prefix carries the domain byte.
                word[8*i +: 8] = PAD_DOMAIN;
            end
            prev_kept = keep[i];
        end
        // When the domain byte lands in the top byte, the two pad bytes merge
        // (0x86 / 0x81).
        if (pad_last) begin
            word[DATA_WIDTH-1 -: 8] = word[DATA_WIDTH-1 -: 8] | PAD_FINAL;
        end
    end

endmodule

// File: rtl/sha3_axis_padder.sv
// Purpose : SHA-3 multi-rate padder; segments an AXI-Stream byte message into rate blocks.
// Latency : 1 cycle from input handshake to m_tvalid (single output register stage).
// Backpressure: s_tready = !m_tvalid || m_tready in DATA, 0 while generating pad words.
// Build option: SHA3_LEGACY_KECCAK_EN selects the Keccak domain byte 0x01 (see sha3_pkg).
// Ports: ACLK/ARESETn (synchronous, active-low) clock and reset;
//        s_t* = input message stream, with s_tuser = mode sampled on the first beat;
//        m_t* = padded words, with m_tlast = end of rate block,
//               m_tid = end of final block, m_tuser = latched mode.
module sha3_axis_padder
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 64   // 8, 16, 32 or 64
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [1:0]              s_tuser,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    m_tid,
    output logic [1:0]              m_tuser
);

    localparam int KW = DATA_WIDTH / 8;

    pad_state_t state, state_nxt;
    sha3_mode_t mode_q, cur_mode;
    logic       msg_start;
    logic [7:0] wcnt;

    logic [7:0] wpb_q, wpb_cur, wcnt_inc, load_idx;
    logic       out_free, s_hs, load_vld, at_last, keep_full;

    logic [DATA_WIDTH-1:0] pw_data, pw_word;
    logic [KW-1:0]         pw_keep;
    logic                  pw_first, pw_last;

    assign out_free = !m_tvalid || m_tready;
    // Gated by ARESETn so that the port reads 0 while reset is held.
    assign s_tready = ARESETn && (state == ST_DATA) && out_free;
    assign s_hs     = s_tvalid && s_tready;

    always_comb begin
        // On the first beat the mode latch has not been loaded yet, so the
        // block length comes straight from s_tuser.
        cur_mode  = msg_start ? sha3_mode_t'(s_tuser) : mode_q;
        wpb_q     = words_per_block(mode_q, DATA_WIDTH);
        wpb_cur   = words_per_block(cur_mode, DATA_WIDTH);
        // wcnt is the index of the word currently presented (or of the next
        // word, when the register is empty). A word loaded while the current
        // word handshakes therefore sits one position further on.
        wcnt_inc  = (wcnt == wpb_q - 8'd1) ? 8'd0 : wcnt + 8'd1;
        load_idx  = m_tvalid ? wcnt_inc : wcnt;
        at_last   = (load_idx == wpb_cur - 8'd1);
        keep_full = &s_tkeep;

        load_vld  = 1'b0;
        pw_data   = '0;
        pw_keep   = '0;
        pw_first  = 1'b0;
        pw_last   = 1'b0;
        state_nxt = state;

        case (state)
            ST_DATA: begin
                load_vld = s_hs;
                pw_data  = s_tdata;
                pw_keep  = s_tlast ? s_tkeep : '1;
                pw_first = s_tlast && !keep_full;
                pw_last  = s_tlast && !keep_full && at_last;
                if (s_hs && s_tlast) begin
                    if (keep_full) begin
                        state_nxt = ST_PAD06;
                    end else if (!at_last) begin
                        state_nxt = ST_PADZ;
                    end
                end
            end
            ST_PAD06: begin
                load_vld = out_free;
                pw_first = 1'b1;
                pw_last  = at_last;
                if (out_free) begin
                    state_nxt = at_last ? ST_DATA : ST_PADZ;
                end
            end
            ST_PADZ: begin
                load_vld = out_free;
                pw_last  = at_last;
                if (out_free && at_last) begin
                    state_nxt = ST_DATA;
                end
            end
            default: begin
                state_nxt = ST_DATA;
            end
        endcase
    end

    sha3_pad_word #(.DATA_WIDTH(DATA_WIDTH)) u_pad_word (
        .data      (pw_data),
        .keep      (pw_keep),
        .pad_first (pw_first),
        .pad_last  (pw_last),
        .word      (pw_word)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= ST_DATA;
            wcnt      <= '0;
            msg_start <= 1'b1;
            mode_q    <= SHA3_224;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            m_tid     <= 1'b0;
            m_tuser   <= '0;
        end else begin
            state <= state_nxt;

            if (m_tvalid && m_tready) begin
                wcnt <= wcnt_inc;
            end

            if (load_vld) begin
                m_tvalid <= 1'b1;
                m_tdata  <= pw_word;
                m_tlast  <= at_last;
                m_tid    <= pw_last;
                m_tuser  <= cur_mode;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            if (s_hs && msg_start) begin
                mode_q <= sha3_mode_t'(s_tuser);
            end
            if (s_hs) begin
                msg_start <= 1'b0;
            end
            // The final word has been generated: the next accepted beat opens
            // a new message (this assignment wins over the clear above).
            if (load_vld && pw_last) begin
                msg_start <= 1'b1;
            end
        end
    end

endmodule
